// File: rtl/mem_bar_responder.sv
// mem_bar_responder: memory-side responder for one accelerator bar.
// Maps the absolute word window [BASE, BASE+DEPTH) onto a single-port RAM and
// returns read data through a fixed READ_LATENCY pipe. It flags out-of-window
// accesses (the first offender is kept) and counts accepted writes.
//
// Output handshake: data_out/rd_valid form a pure valid strobe with no ready
// (no back-pressure). rd_valid is high for exactly one cycle per in-window read,
// READ_LATENCY cycles after that read was sampled. data_out is 0 whenever
// rd_valid is 0. Every cycle with write_en=0 issues a read.
module mem_bar_responder #(
    parameter int          WIDTH        = 64,
    parameter int          DEPTH        = 4096,
    parameter logic [31:0] BASE         = 32'd0,
    parameter int          READ_LATENCY = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_en,
    input  logic [31:0]      addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             err,
    output logic [31:0]      err_addr,
    input  logic             err_clr,
    output logic [31:0]      wr_cnt
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_pipe_dat [READ_LATENCY];
    logic             r_pipe_vld [READ_LATENCY];
    logic             r_err;
    logic [31:0]      r_err_addr;
    logic [31:0]      r_wr_cnt;

    // 33-bit offset: bit 32 set means addr < BASE (a borrow), so no wrap aliasing.
    logic [32:0]      w_off;
    logic             w_in_win;
    logic [IDXW-1:0]  w_idx;
    logic             w_wr_acc;
    logic             w_rd_acc;

    assign w_off    = {1'b0, addr} - {1'b0, BASE};
    assign w_in_win = !w_off[32] && (w_off[31:0] < 32'(DEPTH));
    assign w_idx    = w_off[IDXW-1:0];
    assign w_wr_acc = write_en && w_in_win;
    assign w_rd_acc = !write_en && w_in_win;

    // Storage write port; contents survive rst, but a write sampled with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[w_idx] <= data_in;
        end
    end

    // Read pipe: stage 0 is the RAM output register, later stages just shift.
    // Bubbles carry zero data so a stale word never reaches data_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_dat[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_acc;
            r_pipe_dat[0] <= w_rd_acc ? r_mem[w_idx] : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
        end
    end

    // Sticky error capture: the first offender is held; a new offender beats err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (!w_in_win) begin
            if (!r_err || err_clr) begin
                r_err      <= 1'b1;
                r_err_addr <= addr;
            end
        end else if (err_clr) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end
    end

    // Accepted-write counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
        end else if (w_wr_acc && (r_wr_cnt != 32'hFFFF_FFFF)) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end

    assign data_out = r_pipe_dat[READ_LATENCY-1];
    assign rd_valid = r_pipe_vld[READ_LATENCY-1];
    assign err      = r_err;
    assign err_addr = r_err_addr;
    assign wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_mem_bar_responder.sv
// Testbench for mem_bar_responder: a READ_LATENCY=7 instance checked against a
// reference model with an expected-read queue, plus a READ_LATENCY=1 instance
// for minimum latency and counter saturation.
module tb_mem_bar_responder;

  localparam int LAT = 7;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance signals
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [63:0] din = '0;
  logic        clr = 1'b0;
  logic [63:0] dout;
  logic        rdv;
  logic        err;
  logic [31:0] ea;
  logic [31:0] cnt;

  // latency-1 instance signals
  logic        rst1 = 1'b1;
  logic        we1 = 1'b0;
  logic [31:0] addr1 = '0;
  logic [63:0] din1 = '0;
  logic        clr1 = 1'b0;
  logic [63:0] dout1;
  logic        rdv1;
  logic        err1;
  logic [31:0] ea1;
  logic [31:0] cnt1;

  mem_bar_responder #(.WIDTH(64), .DEPTH(4096), .BASE(32'd0), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .write_en(we), .addr(addr), .data_in(din),
    .data_out(dout), .rd_valid(rdv), .err(err), .err_addr(ea),
    .err_clr(clr), .wr_cnt(cnt)
  );

  mem_bar_responder #(.WIDTH(64), .DEPTH(16), .BASE(32'd0), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .write_en(we1), .addr(addr1), .data_in(din1),
    .data_out(dout1), .rd_valid(rdv1), .err(err1), .err_addr(ea1),
    .err_clr(clr1), .wr_cnt(cnt1)
  );

  // scoreboard state
  logic [63:0] exp_q[$];
  int          due_q[$];
  logic [63:0] m_mem [4096];
  logic        m_err = 1'b0;
  logic [31:0] m_ea = '0;
  logic [31:0] m_cnt = '0;
  logic        p_err = 1'b0;
  logic [31:0] p_ea = '0;
  logic [31:0] p_cnt = '0;
  logic        mon_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // model state becomes visible at the edge that samples the driven inputs
  always @(posedge clk) begin
    p_err <= m_err;
    p_ea  <= m_ea;
    p_cnt <= m_cnt;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // driver: one call = one sampled cycle on the main instance, model updated alongside
  task automatic drive(input logic w, input logic [31:0] a, input logic [63:0] d,
                       input logic c, input logic r);
    logic inwin;
    @(posedge clk);
    #1;
    we = w; addr = a; din = d; clr = c; rst = r;
    inwin = (a < 32'd4096);
    if (r) begin
      m_err = 1'b0; m_ea = '0; m_cnt = '0;
      while (due_q.size() > 0 && due_q[$] >= cyc + 1) begin
        void'(due_q.pop_back());
        void'(exp_q.pop_back());
      end
    end else begin
      if (!inwin) begin
        if (!m_err || c) begin
          m_err = 1'b1;
          m_ea  = a;
        end
      end else if (c) begin
        m_err = 1'b0;
        m_ea  = '0;
      end
      if (w && inwin) begin
        m_mem[a[11:0]] = d;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      if (!w && inwin) begin
        exp_q.push_back(m_mem[a[11:0]]);
        due_q.push_back(cyc + LAT);
      end
    end
  endtask

  task automatic step1(input logic w, input logic [31:0] a, input logic [63:0] d, input logic r);
    @(posedge clk);
    #1;
    we1 = w; addr1 = a; din1 = d; clr1 = 1'b0; rst1 = r;
  endtask

  // monitor: compare outputs against the model every cycle
  always @(negedge clk) begin : mon
    logic [63:0] d;
    int          c;
    if (mon_en) begin
      chk("err", {63'b0, err}, {63'b0, p_err});
      chk("err_addr", {32'b0, ea}, {32'b0, p_ea});
      chk("wr_cnt", {32'b0, cnt}, {32'b0, p_cnt});
      if (rdv) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_valid", {63'b0, rdv}, 64'd0);
        end else begin
          d = exp_q.pop_front();
          c = due_q.pop_front();
          chk("rd_data", dout, d);
          chk("rd_time", 64'(cyc), 64'(c));
        end
      end else begin
        chk("bubble_zero", dout, 64'd0);
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          chk("missing_rd_valid", {63'b0, rdv}, 64'd1);
          void'(due_q.pop_front());
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // ---- latency-1 instance: minimum latency and counter saturation ----
    step1(1'b0, 32'd0, 64'd0, 1'b1);
    step1(1'b0, 32'd0, 64'd0, 1'b1);
    step1(1'b1, 32'd3, 64'hDEAD_BEEF_0000_0003, 1'b0);
    step1(1'b0, 32'd3, 64'd0, 1'b0);
    @(negedge clk);
    chk("l1_bubble_valid", {63'b0, rdv1}, 64'd0);
    chk("l1_bubble_data", dout1, 64'd0);
    chk("l1_wr_cnt", {32'b0, cnt1}, 64'd1);
    @(negedge clk);
    chk("l1_rd_valid", {63'b0, rdv1}, 64'd1);
    chk("l1_rd_data", dout1, 64'hDEAD_BEEF_0000_0003);
    @(posedge clk);
    #1;
    force dut1.r_wr_cnt = 32'hFFFF_FFFD;
    #2;
    release dut1.r_wr_cnt;
    step1(1'b1, 32'd4, 64'd4, 1'b0);
    step1(1'b0, 32'd4, 64'd0, 1'b0);
    @(negedge clk);
    chk("l1_sat_1", {32'b0, cnt1}, 64'hFFFF_FFFE);
    step1(1'b1, 32'd5, 64'd5, 1'b0);
    step1(1'b0, 32'd5, 64'd0, 1'b0);
    @(negedge clk);
    chk("l1_sat_2", {32'b0, cnt1}, 64'hFFFF_FFFF);
    step1(1'b1, 32'd6, 64'd6, 1'b0);
    step1(1'b0, 32'd6, 64'd0, 1'b0);
    @(negedge clk);
    chk("l1_sat_3", {32'b0, cnt1}, 64'hFFFF_FFFF);
    step1(1'b1, 32'd7, 64'd7, 1'b0);
    step1(1'b0, 32'd7, 64'd0, 1'b0);
    @(negedge clk);
    chk("l1_sat_4", {32'b0, cnt1}, 64'hFFFF_FFFF);

    // ---- main instance: reset state ----
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_data_out", dout, 64'd0);
    chk("rst_rd_valid", {63'b0, rdv}, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_err_addr", {32'b0, ea}, 64'd0);
    chk("rst_wr_cnt", {32'b0, cnt}, 64'd0);

    // idle traffic: writes to addr 0 create bubbles
    drive(1'b1, 32'd0, 64'h1234, 1'b0, 1'b0);

    // single write then read at addr 10, bubbles on both sides
    drive(1'b1, 32'd10, 64'hA5A5_0000_0000_0001, 1'b0, 1'b0);
    drive(1'b1, 32'd0, 64'h1234, 1'b0, 1'b0);
    drive(1'b0, 32'd10, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, 32'd0, 64'h1234, 1'b0, 1'b0);

    // preload 0..31 then stream reads back-to-back
    for (int i = 0; i < 32; i++) drive(1'b1, 32'(i), 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) drive(1'b0, 32'(i), 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'd0, 64'd0, 1'b0, 1'b0);

    // read-first ordering: read 5, write 5, read 5 again
    drive(1'b0, 32'd5, 64'd0, 1'b0, 1'b0);
    drive(1'b1, 32'd5, 64'hFF, 1'b0, 1'b0);
    drive(1'b0, 32'd5, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'd0, 64'd0, 1'b0, 1'b0);

    // out-of-window write then read; first offender kept
    drive(1'b1, 32'd4096, 64'h55, 1'b0, 1'b0);
    drive(1'b0, 32'd5000, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("oow_err", {63'b0, err}, 64'd1);
    chk("oow_err_addr_first", {32'b0, ea}, 64'd4096);
    drive(1'b0, 32'd6000, 64'd0, 1'b1, 1'b0);
    drive(1'b1, 32'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("oow_clr_new_wins", {32'b0, ea}, 64'd6000);
    drive(1'b1, 32'd0, 64'd0, 1'b1, 1'b0);
    drive(1'b1, 32'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("err_clr_clears", {63'b0, err}, 64'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'd0, 64'd0, 1'b0, 1'b0);

    // reset with three reads in flight
    drive(1'b0, 32'd10, 64'd0, 1'b0, 1'b0);
    drive(1'b0, 32'd11, 64'd0, 1'b0, 1'b0);
    drive(1'b0, 32'd12, 64'd0, 1'b0, 1'b0);
    drive(1'b1, 32'd20, 64'hBAD, 1'b0, 1'b1);
    drive(1'b0, 32'd10, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_mid_wr_cnt", {32'b0, cnt}, 64'd0);
    for (int i = 0; i < 9; i++) drive(1'b1, 32'd0, 64'd0, 1'b0, 1'b0);
    drive(1'b0, 32'd20, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'd0, 64'd0, 1'b0, 1'b0);

    // random mixed traffic over a preloaded region
    for (int i = 32; i < 64; i++) drive(1'b1, 32'(i), {$urandom, $urandom}, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op <= 3)
        drive(1'b1, 32'($urandom_range(0, 63)), {$urandom, $urandom}, 1'b0, 1'b0);
      else if (op <= 7)
        drive(1'b0, 32'($urandom_range(0, 63)), 64'd0, 1'b0, 1'b0);
      else if (op == 8)
        drive(1'($urandom_range(0, 1)), 32'(4096 + $urandom_range(0, 10000)), 64'd7, 1'($urandom_range(0, 1)), 1'b0);
      else
        drive(1'b0, 32'($urandom_range(0, 63)), 64'd0, 1'b1, 1'b0);
    end

    // drain
    for (int i = 0; i < 10; i++) drive(1'b1, 32'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
